// File: rtl/mac_params.sv
// rtl/mac_params.sv - shared MAC stream parameters and TX arbiter types
package mac_params;

    localparam int N_SYMBOLS = 4;
    localparam int W_SYMBOL  = 8;
    localparam int N_TX_SRC  = 2;
    localparam int W_TX_SRC  = $clog2(N_TX_SRC);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b01,
        ST_PASS = 2'b10
    } mac_tx_arb_state_t;

endpackage

// File: rtl/mac_rr_pick.sv
// rtl/mac_rr_pick.sv - combinational round-robin picker with optional strict priority for index 0
module mac_rr_pick #(
    parameter int N = 2,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] last,
    input  logic         prio_en,
    output logic [N-1:0] grant,
    output logic [W-1:0] idx
);

    logic         found;
    logic [W-1:0] cand;

    // Search starts one past the previous winner and wraps modulo N.
    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        if (prio_en && req[0]) begin
            grant[0] = 1'b1;
        end else begin
            for (int off = 1; off <= N; off++) begin
                cand = W'((int'(last) + off) % N);
                if (!found && req[cand]) begin
                    found       = 1'b1;
                    grant[cand] = 1'b1;
                    idx         = cand;
                end
            end
        end
    end

endmodule

// File: rtl/mac_tx_arb.sv
// rtl/mac_tx_arb.sv - frame-level arbiter onto the MAC TX stream with a one-beat output slice
// Optional strict priority for source 0 with MAC_TX_ARB_PRIO_EN.
module mac_tx_arb
    import mac_params::*;
#(
    parameter int N_SRC = N_TX_SRC
) (
    input  logic                                      i_clk,
    input  logic                                      i_reset,
    input  logic                                      i_clk_en,
    input  logic [N_SRC-1:0]                          s_axis_tvalid,
    input  logic [N_SRC-1:0][N_SYMBOLS-1:0]           s_axis_tkeep,
    input  logic [N_SRC-1:0][N_SYMBOLS-1:0][W_SYMBOL-1:0] s_axis_tdata,
    input  logic [N_SRC-1:0]                          s_axis_tlast,
    output logic [N_SRC-1:0]                          s_axis_tready,
    output logic                                      m_axis_tvalid,
    output logic [N_SYMBOLS-1:0]                      m_axis_tkeep,
    output logic [N_SYMBOLS-1:0][W_SYMBOL-1:0]        m_axis_tdata,
    output logic                                      m_axis_tlast,
    input  logic                                      m_axis_tready,
    output logic [N_SRC-1:0]                          o_grant,
    output logic                                      o_busy,
    output logic                                      o_underrun
);

    localparam int W_SRC = $clog2(N_SRC);
`ifdef MAC_TX_ARB_PRIO_EN
    localparam logic PRIO_EN = 1'b1;
`else
    localparam logic PRIO_EN = 1'b0;
`endif

    mac_tx_arb_state_t q_state, d_state;
    logic [N_SRC-1:0]  q_grant, pick_grant;
    logic [W_SRC-1:0]  q_grant_idx, pick_idx, q_last_src;
    logic              q_m_valid;
    logic              req_any, slot_free, accept, accept_last;

    mac_rr_pick #(
        .N(N_SRC),
        .W(W_SRC)
    ) u_pick (
        .req    (s_axis_tvalid),
        .last   (q_last_src),
        .prio_en(PRIO_EN),
        .grant  (pick_grant),
        .idx    (pick_idx)
    );

    assign req_any     = |s_axis_tvalid;
    assign slot_free   = !q_m_valid || m_axis_tready;
    assign accept      = |(s_axis_tvalid & s_axis_tready);
    assign accept_last = accept && s_axis_tlast[q_grant_idx];

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            q_state <= ST_IDLE;
        end else if (i_clk_en) begin
            q_state <= d_state;
        end
    end

    always_comb begin
        d_state = q_state;
        case (q_state)
            ST_IDLE: if (req_any) d_state = ST_PASS;
            ST_PASS: if (accept_last) d_state = ST_IDLE;
            default: d_state = ST_IDLE;
        endcase
    end

    always_comb begin
        s_axis_tready = '0;
        o_underrun    = 1'b0;
        if (q_state == ST_PASS && i_clk_en) begin
            if (slot_free) s_axis_tready = q_grant;
            o_underrun = slot_free && !(|(s_axis_tvalid & q_grant));
        end
    end

    // Priority mode leaves the rotation pointer alone when source 0 wins.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            q_grant     <= '0;
            q_grant_idx <= '0;
            q_last_src  <= W_SRC'(N_SRC - 1);
        end else if (i_clk_en) begin
            if (q_state == ST_IDLE && req_any) begin
                q_grant     <= pick_grant;
                q_grant_idx <= pick_idx;
            end else if (q_state == ST_PASS && accept_last) begin
                q_grant <= '0;
                if (!PRIO_EN || q_grant_idx != '0) q_last_src <= q_grant_idx;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            q_m_valid    <= 1'b0;
            m_axis_tkeep <= '0;
            m_axis_tdata <= '0;
            m_axis_tlast <= 1'b0;
        end else if (i_clk_en) begin
            if (accept) begin
                q_m_valid    <= 1'b1;
                m_axis_tkeep <= s_axis_tkeep[q_grant_idx];
                m_axis_tdata <= s_axis_tdata[q_grant_idx];
                m_axis_tlast <= s_axis_tlast[q_grant_idx];
            end else if (m_axis_tready) begin
                q_m_valid <= 1'b0;
            end
        end
    end

    assign m_axis_tvalid = q_m_valid;
    assign o_grant       = q_grant;
    assign o_busy        = (q_state == ST_PASS) || q_m_valid;

endmodule

// File: tb/tb_mac_tx_arb.sv
// tb/tb_mac_tx_arb.sv - scoreboard testbench for mac_tx_arb
module tb_mac_tx_arb;
    import mac_params::*;

    localparam int NS = 2;
    localparam int WD = N_SYMBOLS * W_SYMBOL;

    typedef struct packed {
        logic                 last;
        logic [N_SYMBOLS-1:0] keep;
        logic [WD-1:0]        data;
    } beat_t;

    typedef struct {
        int src;
        int gap;
    } gexp_t;

    logic clk = 1'b0;
    logic rst, clk_en, m_tready;
    logic [NS-1:0] s_tvalid, s_tlast, s_tready;
    logic [NS-1:0][N_SYMBOLS-1:0] s_tkeep;
    logic [NS-1:0][N_SYMBOLS-1:0][W_SYMBOL-1:0] s_tdata;
    logic m_tvalid, m_tlast;
    logic [N_SYMBOLS-1:0] m_tkeep;
    logic [N_SYMBOLS-1:0][W_SYMBOL-1:0] m_tdata;
    logic [NS-1:0] grant;
    logic busy, underrun;

    beat_t src0_q[$];
    beat_t src1_q[$];
    beat_t exp_q[$];
    gexp_t gexp_q[$];
    logic [NS-1:0] hold = '0;
    logic [NS-1:0] acc;
    logic [NS-1:0] prev_grant;
    int n_checks = 0, n_errors = 0, ur_count = 0, zero_cnt = 0;

    always #5 clk = ~clk;

    mac_tx_arb #(.N_SRC(NS)) dut (
        .i_clk        (clk),
        .i_reset      (rst),
        .i_clk_en     (clk_en),
        .s_axis_tvalid(s_tvalid),
        .s_axis_tkeep (s_tkeep),
        .s_axis_tdata (s_tdata),
        .s_axis_tlast (s_tlast),
        .s_axis_tready(s_tready),
        .m_axis_tvalid(m_tvalid),
        .m_axis_tkeep (m_tkeep),
        .m_axis_tdata (m_tdata),
        .m_axis_tlast (m_tlast),
        .m_axis_tready(m_tready),
        .o_grant      (grant),
        .o_busy       (busy),
        .o_underrun   (underrun)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic beat_t mk_beat(int src, int frm, int idx, bit last, logic [N_SYMBOLS-1:0] keep);
        beat_t b;
        b.last = last;
        b.keep = keep;
        b.data = WD'({8'(src), 8'(frm), 8'(idx), 8'hA5});
        return b;
    endfunction

    task automatic send_frame(input int src, input int frm, input int n, input logic [N_SYMBOLS-1:0] last_keep);
        beat_t b;
        for (int i = 0; i < n; i++) begin
            b = mk_beat(src, frm, i, (i == n - 1), (i == n - 1) ? last_keep : '1);
            if (src == 0) src0_q.push_back(b);
            else          src1_q.push_back(b);
            exp_q.push_back(b);
        end
    endtask

    task automatic exp_grant(input int src, input int gap);
        gexp_t g;
        g.src = src;
        g.gap = gap;
        gexp_q.push_back(g);
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || gexp_q.size() != 0 || src0_q.size() != 0 ||
                src1_q.size() != 0 || busy) && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk(name, 64'(n < 300), 64'(1));
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3 rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Source driver: presents queue heads, advances after an observed handshake.
    initial begin
        s_tvalid = '0; s_tlast = '0; s_tkeep = '0; s_tdata = '0;
        forever begin
            @(negedge clk);
            acc = s_tvalid & s_tready;
            @(posedge clk);
            #1;
            if (acc[0] && src0_q.size() > 0) void'(src0_q.pop_front());
            if (acc[1] && src1_q.size() > 0) void'(src1_q.pop_front());
            if (src0_q.size() > 0) begin
                s_tvalid[0] = !hold[0];
                {s_tlast[0], s_tkeep[0], s_tdata[0]} = src0_q[0];
            end else begin
                s_tvalid[0] = 1'b0; s_tlast[0] = 1'b0; s_tkeep[0] = '0; s_tdata[0] = '0;
            end
            if (src1_q.size() > 0) begin
                s_tvalid[1] = !hold[1];
                {s_tlast[1], s_tkeep[1], s_tdata[1]} = src1_q[0];
            end else begin
                s_tvalid[1] = 1'b0; s_tlast[1] = 1'b0; s_tkeep[1] = '0; s_tdata[1] = '0;
            end
        end
    end

    // Monitor: output beats and grant sequence against the expected queues.
    always @(negedge clk) begin
        beat_t e;
        gexp_t g;
        if (rst) begin
            prev_grant = '0;
            zero_cnt   = 0;
        end else begin
            if (underrun) ur_count++;
            if (m_tvalid && m_tready && clk_en) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_beat", 64'(exp_q.size()), 64'(1));
                end else begin
                    e = exp_q.pop_front();
                    chk("beat", 64'({m_tlast, m_tkeep, m_tdata}), 64'(e));
                end
            end
            if (grant != '0 && prev_grant == '0) begin
                if (gexp_q.size() == 0) begin
                    chk("spurious_grant", 64'(gexp_q.size()), 64'(1));
                end else begin
                    g = gexp_q.pop_front();
                    chk("grant_src", 64'(grant), 64'(1) << g.src);
                    if (g.gap >= 0) chk("idle_gap", 64'(zero_cnt), 64'(g.gap));
                end
            end
            zero_cnt   = (grant == '0) ? zero_cnt + 1 : 0;
            prev_grant = grant;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int n;
        int ur0;
        logic [WD-1:0] held;
        beat_t b0;

        rst = 1'b1; clk_en = 1'b1; m_tready = 1'b1;
        #2;
        chk("rst_m_tvalid", 64'(m_tvalid), 64'(0));
        chk("rst_m_tlast",  64'(m_tlast),  64'(0));
        chk("rst_m_tkeep",  64'(m_tkeep),  64'(0));
        chk("rst_m_tdata",  64'(m_tdata),  64'(0));
        chk("rst_grant",    64'(grant),    64'(0));
        chk("rst_busy",     64'(busy),     64'(0));
        chk("rst_underrun", 64'(underrun), 64'(0));
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Single 3-beat frame from source 0 with latency checks
        @(negedge clk);
        exp_grant(0, -1);
        send_frame(0, 0, 3, '1);
        b0 = mk_beat(0, 0, 0, 1'b0, '1);
        @(posedge clk); #2;
        chk("t1_no_grant_yet", 64'(grant), 64'(0));
        @(posedge clk); #2;
        chk("t1_grant", 64'(grant), 64'(1));
        chk("t1_ready", 64'(s_tready), 64'(1));
        @(posedge clk); #2;
        chk("t1_m_valid", 64'(m_tvalid), 64'(1));
        chk("t1_beat0", 64'(m_tdata), 64'(b0.data));
        @(posedge clk);
        @(posedge clk); #2;
        chk("t1_grant_clear", 64'(grant), 64'(0));
        chk("t1_tlast", 64'(m_tlast), 64'(1));
        chk("t1_busy_hold", 64'(busy), 64'(1));
        @(posedge clk); #2;
        chk("t1_m_drained", 64'(m_tvalid), 64'(0));
        chk("t1_idle", 64'(busy), 64'(0));
        wait_drain("t1_drain");

        // Both sources streaming 2-beat frames from a fresh reset
        do_reset();
        @(negedge clk);
`ifdef MAC_TX_ARB_PRIO_EN
        exp_grant(0, -1); exp_grant(0, 1); exp_grant(1, 1); exp_grant(1, 1);
        send_frame(0, 0, 2, '1); send_frame(0, 1, 2, '1);
        send_frame(1, 0, 2, '1); send_frame(1, 1, 2, '1);
`else
        exp_grant(0, -1); exp_grant(1, 1); exp_grant(0, 1); exp_grant(1, 1);
        send_frame(0, 0, 2, '1); send_frame(1, 0, 2, '1);
        send_frame(0, 1, 2, '1); send_frame(1, 1, 2, '1);
`endif
        wait_drain("rr_drain");

        // Output back-pressure for 4 cycles mid-frame
        @(negedge clk);
        exp_grant(1, -1);
        send_frame(1, 2, 4, '1);
        n = 0;
        do begin @(negedge clk); n++; end while (!m_tvalid && n < 50);
        chk("stall_start", 64'(m_tvalid), 64'(1));
        @(posedge clk); #2;
        m_tready = 1'b0;
        @(negedge clk);
        held = m_tdata;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            chk("stall_data", 64'(m_tdata), 64'(held));
            chk("stall_ready", 64'(s_tready), 64'(0));
            chk("stall_underrun", 64'(underrun), 64'(0));
        end
        @(posedge clk); #2;
        m_tready = 1'b1;
        wait_drain("stall_drain");
        chk("no_underrun_so_far", 64'(ur_count), 64'(0));

        // Granted source starves the output for 2 cycles
        ur0 = ur_count;
        @(negedge clk);
        exp_grant(0, -1);
        send_frame(0, 3, 3, '1);
        n = 0;
        do begin @(negedge clk); n++; end while (!m_tvalid && n < 50);
        hold[0] = 1'b1;
        @(negedge clk);
        chk("ur_grant_held1", 64'(grant), 64'(1));
        @(negedge clk);
        chk("ur_grant_held2", 64'(grant), 64'(1));
        hold[0] = 1'b0;
        wait_drain("ur_drain");
        chk("ur_pulses", 64'(ur_count - ur0), 64'(2));

        // Reset mid-frame while the clock enable toggles
        @(negedge clk);
        exp_grant(0, -1);
        send_frame(0, 4, 6, '1);
        repeat (8) begin @(posedge clk); #2 clk_en = ~clk_en; end
        @(posedge clk); #2;
        chk("pre_rst_busy", 64'(busy), 64'(1));
        chk("pre_rst_m_valid", 64'(m_tvalid), 64'(1));
        #1 rst = 1'b1;
        src0_q.delete();
        exp_q.delete();
        #1;
        chk("arst_m_tvalid", 64'(m_tvalid), 64'(0));
        chk("arst_m_tdata",  64'(m_tdata),  64'(0));
        chk("arst_m_tlast",  64'(m_tlast),  64'(0));
        chk("arst_grant",    64'(grant),    64'(0));
        chk("arst_busy",     64'(busy),     64'(0));
        chk("arst_ready",    64'(s_tready), 64'(0));
        repeat (3) begin @(posedge clk); #2 clk_en = ~clk_en; end
        clk_en = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("post_rst_grant", 64'(grant), 64'(0));

        @(negedge clk);
        exp_grant(0, -1); exp_grant(1, 1);
        send_frame(0, 5, 1, '1);
        send_frame(1, 5, 1, '0);
        wait_drain("post_rst_drain");
        chk("final_exp_empty", 64'(exp_q.size()), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
